xbar_master_port: RTL

Parametrised master-side agent of the crossbar. Accepts read/write requests from a core through a valid/ready interface and buffers them in a DEPTH-entry FIFO. Issues them one at a time to the crossbar with a held req/ack handshake and returns one response per request (read data, write completion, or optional timeout error). Successor to the fixed 32-bit single-request master; adds width parameters, request queuing, response reporting and an optional timeout.

---
 rtl/xbar_pkg.sv | 17 +
 rtl/xbar_master_port_fifo.sv | 63 ++++++
 rtl/xbar_master_port.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/xbar_pkg.sv
// Shared definitions for the crossbar master port: FSM encoding, command codes
// and the request width helper.
package xbar_pkg;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] WAIT = 2'b01;
    localparam logic [1:0] READ = 2'b10;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    // Packed request layout is {cmd, addr, wdata}.
    function automatic int req_width(input int aw, input int dw);
        return aw + dw + 1;
    endfunction

endpackage

// File: rtl/xbar_master_port_fifo.sv
// Synchronous request FIFO for the master port.
// The full flag is registered; level counts stored entries.
module xbar_req_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] LVL_FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      level_q, level_d;
    logic             full_q;
    logic             do_push, do_pop;

    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & (level_q != '0);

    always_comb begin
        level_d = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + 1'b1;
        end else if (do_pop && !do_push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            full_q  <= (level_d == LVL_FULL);
        end
    end

    // Storage needs no reset: entries are only read while counted in level.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

endmodule

// File: rtl/xbar_master_port.sv
// Crossbar master port: queues core requests and issues them one at a time
// with a held req/ack handshake. Optional WAIT timeout: XBAR_MST_TIMEOUT_EN.
//
// state | meaning
// IDLE  | outputs parked at 0; pops the FIFO head when one is queued
// WAIT  | o_req held with the issued request until ack (or timeout)
// READ  | captures i_rdata the cycle after a read ack
module xbar_master_port
    import xbar_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     t_req,
    output logic                     t_ready,
    input  logic                     t_cmd,
    input  logic [AW-1:0]            t_addr,
    input  logic [DW-1:0]            t_wdata,
    output logic                     o_req,
    output logic                     o_cmd,
    output logic [AW-1:0]            o_addr,
    output logic [DW-1:0]            o_wdata,
    input  logic                     ack,
    input  logic [DW-1:0]            i_rdata,
    output logic                     save_req,
    output logic                     r_valid,
    output logic [DW-1:0]            r_data,
    output logic                     r_err,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int RW = req_width(AW, DW);

    typedef struct packed {
        logic          cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    req_t             push_req, head;
    logic [RW-1:0]    fifo_dout;
    logic             fifo_full, fifo_empty, pop;
    logic             tmo_fire;

    logic [1:0]       state_q, state_d;
    logic             o_req_q, o_req_d;
    logic             o_cmd_q, o_cmd_d;
    logic [AW-1:0]    o_addr_q, o_addr_d;
    logic [DW-1:0]    o_wdata_q, o_wdata_d;
    logic             r_valid_q, r_valid_d;
    logic [DW-1:0]    r_data_q, r_data_d;

    assign push_req = '{cmd: t_cmd, addr: t_addr, wdata: t_wdata};
    assign head     = req_t'(fifo_dout);

    xbar_req_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (t_req),
        .din_i   (push_req),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    always_comb begin
        state_d   = state_q;
        o_req_d   = o_req_q;
        o_cmd_d   = o_cmd_q;
        o_addr_d  = o_addr_q;
        o_wdata_d = o_wdata_q;
        r_valid_d = 1'b0;
        r_data_d  = r_data_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    o_req_d   = 1'b1;
                    o_cmd_d   = head.cmd;
                    o_addr_d  = head.addr;
                    o_wdata_d = head.wdata;
                    state_d   = WAIT;
                end else begin
                    o_req_d   = 1'b0;
                    o_cmd_d   = CMD_READ;
                    o_addr_d  = '0;
                    o_wdata_d = '0;
                end
            end
            WAIT: begin
                // The issued command is parked once the handshake ends.
                if (ack) begin
                    o_req_d   = 1'b0;
                    o_cmd_d   = CMD_READ;
                    o_addr_d  = '0;
                    o_wdata_d = '0;
                    if (o_cmd_q == CMD_READ) begin
                        state_d = READ;
                    end else begin
                        r_valid_d = 1'b1;
                        r_data_d  = '0;
                        state_d   = IDLE;
                    end
                end else if (tmo_fire) begin
                    o_req_d   = 1'b0;
                    o_cmd_d   = CMD_READ;
                    o_addr_d  = '0;
                    o_wdata_d = '0;
                    r_valid_d = 1'b1;
                    r_data_d  = '0;
                    state_d   = IDLE;
                end
            end
            READ: begin
                r_data_d  = i_rdata;
                r_valid_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            o_req_q   <= 1'b0;
            o_cmd_q   <= CMD_READ;
            o_addr_q  <= '0;
            o_wdata_q <= '0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            o_req_q   <= o_req_d;
            o_cmd_q   <= o_cmd_d;
            o_addr_q  <= o_addr_d;
            o_wdata_q <= o_wdata_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
        end
    end

`ifdef XBAR_MST_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] tmo_cnt_q;
    logic          r_err_q;

    // Counter is zero whenever WAIT is entered; ack on the last cycle wins.
    assign tmo_fire = (state_q == WAIT) & ~ack & (tmo_cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q <= '0;
            r_err_q   <= 1'b0;
        end else begin
            r_err_q <= tmo_fire;
            if (state_q != WAIT) begin
                tmo_cnt_q <= '0;
            end else if (!ack) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
        end
    end

    assign r_err = r_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign tmo_fire       = 1'b0;
    assign r_err          = 1'b0;
`endif

    assign t_ready  = ~fifo_full;
    assign o_req    = o_req_q;
    assign o_cmd    = o_cmd_q;
    assign o_addr   = o_addr_q;
    assign o_wdata  = o_wdata_q;
    assign save_req = o_req_q & ~ack;
    assign r_valid  = r_valid_q;
    assign r_data   = r_data_q;

endmodule
